// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : riscv_pkg
// Brief   : Shared widths, constants and fetch-state encoding.
// Revision: 1.0
// ============================================================================
package riscv_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_BOOT   = 2'd0,
    FETCH_RUN    = 2'd1,
    FETCH_HALTED = 2'd2
  } fetch_state_t;

  // Instruction fetch is word-aligned; low two bits are always dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : fetch_queue
// Brief   : Two-entry FIFO of {pc, instr} with registered head and flush.
// Revision: 1.0
// ============================================================================
module fetch_queue
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_pc,
  input  logic [XLEN-1:0] push_instr,
  output logic [1:0]      count,
  output logic            valid,
  output logic [XLEN-1:0] head_pc,
  output logic [XLEN-1:0] head_instr
);

  logic [1:0]      r_count;
  logic [XLEN-1:0] r_head_pc;
  logic [XLEN-1:0] r_head_instr;
  logic [XLEN-1:0] r_tail_pc;
  logic [XLEN-1:0] r_tail_instr;

  logic w_pop_ok;
  logic w_push_ok;

  // Guards keep the occupancy inside 0..2 regardless of caller behaviour.
  assign w_pop_ok  = pop && (r_count != 2'd0);
  assign w_push_ok = push && ((r_count != 2'd2) || w_pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count      <= 2'd0;
      r_head_pc    <= '0;
      r_head_instr <= '0;
      r_tail_pc    <= '0;
      r_tail_instr <= '0;
    end else if (flush) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push_ok, w_pop_ok})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head_pc    <= push_pc;
            r_head_instr <= push_instr;
          end else begin
            r_tail_pc    <= push_pc;
            r_tail_instr <= push_instr;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head_pc    <= r_tail_pc;
          r_head_instr <= r_tail_instr;
          r_count      <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head_pc    <= push_pc;
            r_head_instr <= push_instr;
          end else begin
            r_head_pc    <= r_tail_pc;
            r_head_instr <= r_tail_instr;
            r_tail_pc    <= push_pc;
            r_tail_instr <= push_instr;
          end
        end
        default: ;
      endcase
    end
  end

  assign count      = r_count;
  assign valid      = (r_count != 2'd0);
  assign head_pc    = r_head_pc;
  assign head_instr = r_head_instr;

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : pc_fetch_unit
// Brief   : PC generator and BOOT/RUN/HALTED fetch control feeding a 2-deep queue.
// Revision: 1.0
// ============================================================================
module pc_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] PC,
  input  logic [31:0] instr_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam logic [1:0] c_qdepth = 2'(QDEPTH);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic         w_push;
  logic         w_pop;
  logic         w_flush;
  logic         w_full;
  logic [1:0]   w_count;
  logic         w_valid;

  assign w_full = (w_count == c_qdepth);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FETCH_BOOT;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Redirect outranks everything: flush, load aligned target, resume fetching.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    w_flush     = 1'b0;
    w_pop       = w_valid && out_ready;
    if (redirect_valid) begin
      w_flush     = 1'b1;
      w_pop       = 1'b0;
      w_pc_nxt    = align_pc(redirect_target);
      w_state_nxt = FETCH_RUN;
    end else begin
      case (r_state)
        FETCH_BOOT: begin
          w_state_nxt = FETCH_RUN;
        end
        FETCH_RUN: begin
          if (halt_req) begin
            w_state_nxt = FETCH_HALTED;
          end else if (!w_full || w_pop) begin
            w_push   = 1'b1;
            w_pc_nxt = r_pc + 32'd4;
          end
        end
        FETCH_HALTED: ;
        default: w_state_nxt = FETCH_BOOT;
      endcase
    end
  end

  fetch_queue u_fetch_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (w_flush),
    .push       (w_push),
    .pop        (w_pop),
    .push_pc    (r_pc),
    .push_instr (instr_in),
    .count      (w_count),
    .valid      (w_valid),
    .head_pc    (out_pc),
    .head_instr (out_instr)
  );

  assign PC        = r_pc;
  assign out_valid = w_valid;

endmodule
`default_nettype wire

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter: QDEPTH, 2, fetch-queue entries (fixed at 2).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port: clk  in  1  rising-edge clock.
REQ-005 SHALL have port: rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have port: PC  out  32  address driven to the instruction memory.
REQ-007 SHALL have port: instr_in  in  32  instruction word returned combinationally for PC.
REQ-008 SHALL have port: redirect_valid  in  1  branch/jump taken; flush and reload PC.
REQ-009 SHALL have port: redirect_target  in  32  new fetch address.
REQ-010 SHALL have port: halt_req  in  1  stop fetching (level).
REQ-011 SHALL have port: out_valid  out  1  decode-side entry available.
REQ-012 SHALL have port: out_ready  in  1  decode accepts head entry.
REQ-013 SHALL have port: out_instr  out  32  head instruction.
REQ-014 SHALL have port: out_pc  out  32  PC of head instruction.

Function
REQ-015 SHALL implement states BOOT, RUN, HALTED; reset enters BOOT.
REQ-016 BOOT SHALL last exactly one cycle: PC=RESET_PC, no push, then RUN.
REQ-017 In RUN, push of {PC, instr_in} SHALL occur when count<2 or a pop occurs that cycle; on push, PC advances by 4.
REQ-018 PC arithmetic SHALL be modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0).
REQ-019 out_valid SHALL equal (count!=0); out_instr/out_pc SHALL show the oldest entry, registered.
REQ-020 Pop SHALL occur when out_valid && out_ready; ordering is FIFO.
REQ-021 Latency: word at PC captured at edge N SHALL be visible on out_* after edge N when the queue was empty.
REQ-022 Full queue with out_ready=0: PC and contents SHALL hold; no overwrite.
REQ-023 Simultaneous push and pop with count=2 SHALL keep count=2 and shift in the new entry.
REQ-024 redirect_valid SHALL take priority over push, pop and halt: count<=0, PC<=target with bits [1:0] forced to 00, no push that cycle; a simultaneous pop is discarded.
REQ-025 Redirect in any state other than BOOT SHALL enter RUN; redirect during BOOT SHALL load PC and still enter RUN after the BOOT cycle.
REQ-026 halt_req in RUN (without redirect) SHALL enter HALTED at next edge; no pushes in HALTED; queue drains normally; PC holds.
REQ-027 HALTED SHALL exit only on redirect_valid; deasserting halt_req alone SHALL not resume.
REQ-028 count SHALL never exceed 2 or underflow below 0.

Reset
REQ-029 Reset SHALL force PC=RESET_PC, count=0, out_valid=0, out_instr=32'h0, out_pc=32'h0, state=BOOT, asynchronously.
REQ-030 Reset asserted mid-operation SHALL discard all queue contents and pending redirect; first push after release occurs on the second edge.

Structure
REQ-031 Shared package riscv_pkg SHALL hold XLEN=32, NOP=32'h0000_0013, the fetch state encoding and default RESET_PC.
REQ-032 The queue SHALL be a sub-module fetch_queue (2-entry, push/pop/flush, count output); PC, FSM and next-PC logic stay in pc_fetch_unit.

Verification
REQ-033 Reset release, out_ready=1, memory returns 32'h00400...: PC sequence 0,4,8,12; out_pc 0 appears after edge 2; one instruction per cycle.
REQ-034 out_ready=0 for 5 cycles from reset: count saturates at 2, PC holds at 8, out_pc stays 0; release drains 0,4 then 8.
REQ-035 redirect_valid with target 32'h0000_0013 while count=2 and out_ready=1: next cycle out_valid=0, PC=32'h0000_0010; next out_pc=32'h10.
REQ-036 halt_req pulsed at PC=16, out_ready=1: HALTED, queue drains, PC stays 16; halt_req low keeps halt; redirect to 32'h40 resumes at 0x40.
REQ-037 RESET_PC=32'hFFFF_FFF8: fetch sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 rst asserted for one cycle with count=2 mid-run: outputs zero immediately; after release BOOT then fetch from RESET_PC.
